// File: rtl/qrs_peak_search.sv
// QRS peak search: tracks the largest short-window abs-diff sample above threshold
// and confirms it as a peak once LOOKAHEAD samples pass without a larger one.
module qrs_peak_search #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 24,
  parameter int LOOKAHEAD  = 36,
  parameter int REFRACTORY = 72
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_qrs_search_en,
  input  logic [DATA_WIDTH-1:0] i_qrs_threshold,
  output logic [CTR_WIDTH-1:0]  o_ctr,
  output logic [DATA_WIDTH-1:0] o_abs_diff_short_max,
  output logic                  o_abs_diff_short_valid,
  output logic                  o_extremum_found
);

  localparam int LA_W = $clog2(LOOKAHEAD + 1);
  localparam int RF_W = $clog2(REFRACTORY + 1);
  localparam logic [LA_W-1:0] LA_LAST = LA_W'(LOOKAHEAD);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRACTORY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACK   = 2'd2,
    REFRACT = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [CTR_WIDTH-1:0]  ctr_reg, ctr_next;
  logic [DATA_WIDTH-1:0] max_reg, max_next;
  logic [DATA_WIDTH-1:0] track_reg, track_next;
  logic [LA_W-1:0]       la_reg, la_next;
  logic [RF_W-1:0]       rf_reg, rf_next;
  logic                  valid_reg, valid_next;
  logic                  pulse_reg, pulse_next;

  logic [LA_W-1:0]       la_sat;
  logic [RF_W-1:0]       rf_sat;

  // Saturating increments: the counters never wrap even if a state lingers.
  assign la_sat = (la_reg == LA_LAST) ? la_reg : la_reg + LA_W'(1);
  assign rf_sat = (rf_reg == RF_LAST) ? rf_reg : rf_reg + RF_W'(1);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= IDLE;
      ctr_reg   <= '0;
      max_reg   <= '0;
      track_reg <= '0;
      la_reg    <= '0;
      rf_reg    <= '0;
      valid_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
      max_reg   <= max_next;
      track_reg <= track_next;
      la_reg    <= la_next;
      rf_reg    <= rf_next;
      valid_reg <= valid_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctr_next   = i_ce ? ctr_reg + CTR_WIDTH'(1) : ctr_reg;
    valid_next = valid_reg | i_ce;
    max_next   = max_reg;
    track_next = track_reg;
    la_next    = la_reg;
    rf_next    = rf_reg;
    pulse_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Enabling freezes the initialisation maximum even on a sample cycle.
        if (i_qrs_search_en) begin
          state_next = ARMED;
        end else if (i_ce && (i_sample > max_reg)) begin
          max_next = i_sample;
        end
      end

      ARMED: begin
        if (!i_qrs_search_en) begin
          state_next = IDLE;
          max_next   = '0;
          track_next = '0;
          la_next    = '0;
        end else if (i_ce && (i_sample > i_qrs_threshold)) begin
          state_next = TRACK;
          track_next = i_sample;
          la_next    = '0;
        end
      end

      TRACK: begin
        if (!i_qrs_search_en) begin
          state_next = IDLE;
          max_next   = '0;
          track_next = '0;
          la_next    = '0;
        end else if (i_ce) begin
          // Equal samples do not restart the lookahead: the first occurrence wins.
          if (i_sample > track_reg) begin
            track_next = i_sample;
            la_next    = '0;
          end else begin
            la_next = la_sat;
            if (la_sat == LA_LAST) begin
              state_next = REFRACT;
              max_next   = track_reg;
              pulse_next = 1'b1;
              la_next    = '0;
              rf_next    = '0;
            end
          end
        end
      end

      REFRACT: begin
        if (i_ce) begin
          rf_next = rf_sat;
          if (rf_sat == RF_LAST) begin
            state_next = i_qrs_search_en ? ARMED : IDLE;
            rf_next    = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_ctr                  = ctr_reg;
  assign o_abs_diff_short_max   = max_reg;
  assign o_abs_diff_short_valid = valid_reg;
  assign o_extremum_found       = pulse_reg;

endmodule

// File: tb/tb_qrs_peak_search.sv
// Directed bench for qrs_peak_search; expected peaks are queued by the stimulus
// and a monitor checks each o_extremum_found pulse against the queue head.
module tb_qrs_peak_search;

  localparam int DW = 11;
  localparam int CW = 9;   // narrow counter so the wrap is reachable quickly
  localparam int LA = 36;
  localparam int RF = 72;

  logic          clk    = 1'b0;
  logic          nrst   = 1'b0;
  logic          ce     = 1'b0;
  logic          en     = 1'b0;
  logic [DW-1:0] sample = '0;
  logic [DW-1:0] thr    = DW'(100);

  logic [CW-1:0] ctr;
  logic [DW-1:0] dmax;
  logic          valid;
  logic          found;

  qrs_peak_search #(
    .DATA_WIDTH(DW),
    .CTR_WIDTH (CW),
    .LOOKAHEAD (LA),
    .REFRACTORY(RF)
  ) dut (
    .i_clk                 (clk),
    .i_nrst                (nrst),
    .i_ce                  (ce),
    .i_sample              (sample),
    .i_qrs_search_en       (en),
    .i_qrs_threshold       (thr),
    .o_ctr                 (ctr),
    .o_abs_diff_short_max  (dmax),
    .o_abs_diff_short_valid(valid),
    .o_extremum_found      (found)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int at;
  } peak_t;

  peak_t exp_q[$];
  peak_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    n_done = 0;

  // Number of samples consumed so far, counted by the bench itself.
  always @(posedge clk) if (ce) n_done++;

  always @(negedge clk) begin
    if (nrst && found === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pulse after sample %0d with max %0d, required no pulse", n_done, dmax);
      end else begin
        mon_e = exp_q.pop_front();
        if (dmax !== DW'(mon_e.value) || n_done != mon_e.at) begin
          errors++;
          $display("FAIL peak: max %0d after sample %0d, required max %0d after sample %0d",
                   dmax, n_done, mon_e.value, mon_e.at);
        end else begin
          $display("peak ok: max %0d after sample %0d", dmax, n_done);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic send(input int s);
    @(negedge clk);
    sample = DW'(s);
    ce     = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic sendn(input int s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("rst_ctr", ctr, 0);
    check("rst_max", dmax, 0);
    check("rst_valid", valid, 0);
    check("rst_pulse", found, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Initialisation maximum with search disabled
    send(5);
    check("init_valid_first", valid, 1);
    check("init_max_first", dmax, 5);
    idle(2);
    check("ce_low_ctr_hold", ctr, 1);
    send(200);
    send(17);
    send(150);
    check("init_max", dmax, 200);
    check("init_ctr", ctr, 4);

    // Enable goes to ARMED without a sample strobe; max is held
    @(negedge clk);
    en = 1'b1;
    idle(1);
    check("armed_max_hold", dmax, 200);
    check("armed_ctr_hold", ctr, 4);

    // Detection: 250 and 35 zeros are the 36 non-increasing samples
    exp_q.push_back('{300, 43});
    send(50);
    send(120);
    send(300);
    send(250);
    check("track_max_hold", dmax, 200);
    sendn(0, 35);
    check("det_pulse", found, 1);
    check("det_max", dmax, 300);
    send(0);
    check("det_pulse_one_cycle", found, 0);
    check("det_max_after1", dmax, 300);
    idle(2);
    check("det_max_after3", dmax, 300);

    // Refractory: 500 inside the window ignored, 500 afterwards detected
    exp_q.push_back('{500, 152});
    send(500);
    check("refr_max_hold", dmax, 300);
    sendn(0, 70);
    send(500);
    sendn(0, 36);
    check("refr_peak_max", dmax, 500);

    // Threshold boundary: 100 does not arm tracking, 101 does
    sendn(0, 72);
    send(100);
    sendn(0, 36);
    check("thr_eq_no_peak", dmax, 500);
    exp_q.push_back('{101, 298});
    send(101);
    sendn(0, 36);
    check("thr_above_peak", dmax, 101);

    // Abort during TRACK
    sendn(0, 72);
    send(200);
    sendn(0, 5);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_max_clear", dmax, 0);
    check("abort_no_pulse", found, 0);
    send(7);
    check("abort_accum1", dmax, 7);
    send(3);
    check("abort_accum2", dmax, 7);

    // Counter wrap
    check("ctr_before_wrap", ctr, 378);
    sendn(0, 133);
    check("ctr_top", ctr, 511);
    send(0);
    check("ctr_wrap", ctr, 0);

    // Asynchronous reset in the middle of TRACK
    @(negedge clk);
    en = 1'b1;
    idle(1);
    send(300);
    sendn(0, 10);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("amid_rst_ctr", ctr, 0);
    check("amid_rst_max", dmax, 0);
    check("amid_rst_valid", valid, 0);
    check("amid_rst_pulse", found, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    nrst = 1'b1;
    en   = 1'b0;
    send(9);
    check("post_rst_idle_max", dmax, 9);
    check("post_rst_ctr", ctr, 1);
    idle(40);

    check("pending_peaks", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qrs_peak_search.md
QRS_PEAK_SEARCH -- requirements
Module: qrs_peak_search

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 11, the sample and threshold width in bits.
REQ-002 The module SHALL have parameter CTR_WIDTH, default 24, the sample counter width in bits.
REQ-003 The module SHALL have parameter LOOKAHEAD, default 36, the number of samples without a new maximum that confirms a peak (100 ms at 360 Hz).
REQ-004 The module SHALL have parameter REFRACTORY, default 72, the number of samples ignored after a confirmed peak (200 ms).
REQ-005 i_clk  input  1  clock; reset is i_nrst, asynchronous, active-low.
REQ-006 i_nrst  input  1  asynchronous active-low reset.
REQ-007 i_ce  input  1  sample strobe; all sample-domain state advances only on cycles with i_ce=1.
REQ-008 i_sample  input  DATA_WIDTH  unsigned short-window absolute-difference sample.
REQ-009 i_qrs_search_en  input  1  search enable from the algorithm FSM.
REQ-010 i_qrs_threshold  input  DATA_WIDTH  unsigned detection threshold.
REQ-011 o_ctr  output  CTR_WIDTH  free-running sample index.
REQ-012 o_abs_diff_short_max  output  DATA_WIDTH  running maximum, or the value of the last confirmed peak.
REQ-013 o_abs_diff_short_valid  output  1  level signal: at least one sample has been processed since reset.
REQ-014 o_extremum_found  output  1  one-clock pulse marking a confirmed peak.

Function
REQ-015 o_ctr SHALL increment by 1 on each i_ce cycle and SHALL wrap from 2^CTR_WIDTH-1 to 0.
REQ-016 o_abs_diff_short_valid SHALL rise on the clock edge of the first i_ce cycle after reset and SHALL then stay high until reset.
REQ-017 The FSM SHALL have four states: IDLE, ARMED, TRACK and REFRACT.
REQ-018 In IDLE, on each i_ce cycle, o_abs_diff_short_max SHALL be updated to max(o_abs_diff_short_max, i_sample); this gives an initialisation-period maximum.
REQ-019 IDLE->ARMED SHALL occur on the first clock with i_qrs_search_en=1, and o_abs_diff_short_max SHALL be held from that point.
REQ-020 ARMED->TRACK SHALL occur on an i_ce cycle with i_sample > i_qrs_threshold (strict), loading the tracked maximum with i_sample and clearing the lookahead count to 0.
REQ-021 In TRACK, on each i_ce cycle, if i_sample > tracked maximum the maximum SHALL be replaced and the count cleared; otherwise the count SHALL increment.
REQ-022 A sample equal to the tracked maximum SHALL NOT count as a new maximum; the first occurrence is kept.
REQ-023 When the count reaches LOOKAHEAD, the FSM SHALL copy the tracked maximum to o_abs_diff_short_max, assert o_extremum_found for exactly one i_clk cycle, and enter REFRACT.
REQ-024 o_abs_diff_short_max SHALL then remain stable until the next ARMED->TRACK transition, which is at least REFRACTORY samples later.
REQ-025 REFRACT SHALL ignore samples for REFRACTORY i_ce cycles and then go to ARMED, or to IDLE if i_qrs_search_en=0.
REQ-026 If i_qrs_search_en falls in ARMED or TRACK, the FSM SHALL return to IDLE on the next clock with no pulse, and the tracked maximum SHALL be discarded.
REQ-027 When re-entering IDLE from ARMED or TRACK, o_abs_diff_short_max SHALL be cleared to 0 before running-maximum accumulation restarts.
REQ-028 When i_ce=0, no counter, maximum or state SHALL change, except the immediate transitions driven by i_qrs_search_en.
REQ-029 The lookahead and refractory counters SHALL saturate and SHALL never wrap.
REQ-030 All comparisons SHALL be unsigned at DATA_WIDTH.

Reset
REQ-031 Asserting i_nrst low SHALL immediately force state IDLE, o_ctr=0, o_abs_diff_short_max=0, o_abs_diff_short_valid=0, o_extremum_found=0, and all internal counters to 0.
REQ-032 Reset asserted mid-TRACK or mid-REFRACT SHALL abort with no pulse.
REQ-033 After reset release, operation SHALL resume in IDLE.

Verification
REQ-034 Init max: search_en=0, samples 5,200,17,150 -> o_abs_diff_short_max=200, valid high after the first sample, o_ctr=4.
REQ-035 Detection: en=1, threshold=100, samples 50,120,300,250 followed by 36 samples of 0 -> exactly one pulse, on the 36th non-increasing sample; max=300 and held for at least 2 cycles after the pulse.
REQ-036 Threshold boundary: sample equal to threshold (100) -> stays ARMED with no pulse; sample 101 -> enters TRACK.
REQ-037 Refractory: a sample of 500 within 72 samples after a pulse -> ignored; a sample of 500 after 72 samples -> TRACK, then a pulse with max=500.
REQ-038 Abort: search_en dropped during TRACK -> IDLE, no pulse, max=0, then accumulates the running max.
REQ-039 Wrap/reset: with o_ctr=2^24-1, one i_ce cycle -> 0; i_nrst pulsed mid-TRACK -> all outputs 0 immediately.
